// File: rtl/cmp_frame_stats.sv
`default_nettype none
//============================================================================
// Module   : cmp_frame_stats
// Purpose  : Frame-statistics sequencer wrapped around an external
//            combinational 4-bit magnitude comparator. For every accepted
//            sample it presents (current, previous) to the comparator, reads
//            back the gt/eq/lt flags in the same cycle and accumulates
//            rise/same/fall counts plus frame max/min. After FRAME_LEN
//            samples a registered result record is offered on out_valid.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready/in_data      - 4-bit sample stream
//            cmp_a/cmp_b, cmp_gt/eq/lt      - comparator operands and flags
//            out_valid/out_ready            - result record handshake
//            max_val, min_val, n_rise, n_same, n_fall - record fields
//            flag_err                       - only with CMP_ONEHOT_CHECK_EN
// Options  : `define CMP_ONEHOT_CHECK_EN adds a sticky flag_err output and
//            drops the count update for any sample whose comparator flags
//            are not exactly one-hot.
// Revision : 1.0 - initial release
//============================================================================
module cmp_frame_stats #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    output logic [3:0]       cmp_a,
    output logic [3:0]       cmp_b,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       max_val,
    output logic [3:0]       min_val,
    output logic [CNT_W-1:0] n_rise,
    output logic [CNT_W-1:0] n_same,
`ifdef CMP_ONEHOT_CHECK_EN
    output logic [CNT_W-1:0] n_fall,
    output logic             flag_err
`else
    output logic [CNT_W-1:0] n_fall
`endif
);

    typedef enum logic [1:0] {
        ST_FIRST  = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    localparam logic [3:0] c_last_idx = 4'(FRAME_LEN - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_prev;
    logic [3:0]       r_max;
    logic [3:0]       r_min;
    logic [3:0]       r_idx;
    logic [CNT_W-1:0] r_rise;
    logic [CNT_W-1:0] r_same;
    logic [CNT_W-1:0] r_fall;
    logic             w_accept;
    logic             w_inc_rise;
    logic             w_inc_same;
    logic             w_inc_fall;

    assign w_accept = in_valid && in_ready;

    // Comparator sees the live sample against the previously accepted one.
    assign cmp_a = in_data;
    assign cmp_b = r_prev;

`ifdef CMP_ONEHOT_CHECK_EN
    logic w_onehot;
    logic r_err;

    // Exactly one of three: odd parity rules out 0 and 2 set, AND rules out 3.
    assign w_onehot   = (cmp_gt ^ cmp_eq ^ cmp_lt) & ~(cmp_gt & cmp_eq & cmp_lt);
    assign w_inc_rise = w_onehot & cmp_gt;
    assign w_inc_same = w_onehot & cmp_eq;
    assign w_inc_fall = w_onehot & cmp_lt;
    assign flag_err   = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == ST_ACCUM && w_accept && !w_onehot) begin
            r_err <= 1'b1;
        end
    end
`else
    // Priority gt > eq > lt; all-low flags fall through to a fall.
    assign w_inc_rise = cmp_gt;
    assign w_inc_same = !cmp_gt && cmp_eq;
    assign w_inc_fall = !cmp_gt && !cmp_eq;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FIRST;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_FIRST: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_next_state = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (w_accept && r_idx == c_last_idx) begin
                    w_next_state = ST_REPORT;
                end
            end
            ST_REPORT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_FIRST;
                end
            end
            default: begin
                w_next_state = ST_FIRST;
            end
        endcase
    end

    // Record registers only move on an accepted sample, so they are
    // naturally frozen while in REPORT (in_ready is low there).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 4'd0;
            r_max  <= 4'd0;
            r_min  <= 4'd0;
            r_idx  <= 4'd0;
            r_rise <= '0;
            r_same <= '0;
            r_fall <= '0;
        end else if (w_accept) begin
            r_prev <= in_data;
            if (r_state == ST_FIRST) begin
                r_max  <= in_data;
                r_min  <= in_data;
                r_idx  <= 4'd1;
                r_rise <= '0;
                r_same <= '0;
                r_fall <= '0;
            end else begin
                if (in_data > r_max) begin
                    r_max <= in_data;
                end
                if (in_data < r_min) begin
                    r_min <= in_data;
                end
                r_idx <= r_idx + 4'd1;
                if (w_inc_rise) begin
                    r_rise <= r_rise + CNT_W'(1);
                end
                if (w_inc_same) begin
                    r_same <= r_same + CNT_W'(1);
                end
                if (w_inc_fall) begin
                    r_fall <= r_fall + CNT_W'(1);
                end
            end
        end
    end

    assign max_val = r_max;
    assign min_val = r_min;
    assign n_rise  = r_rise;
    assign n_same  = r_same;
    assign n_fall  = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_cmp_frame_stats.sv
`default_nettype none
//============================================================================
// Module   : tb_cmp_frame_stats
// Purpose  : Self-checking bench for cmp_frame_stats with FRAME_LEN=4.
//            Acts as the external comparator (with optional flag faults),
//            applies a vector table, reset and backpressure sequences, and
//            random frames checked against a frame-level reference model.
// Revision : 1.0 - initial release
//============================================================================
module tb_cmp_frame_stats;

    localparam int FL = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_data;
    logic [3:0]    cmp_a;
    logic [3:0]    cmp_b;
    logic          cmp_gt;
    logic          cmp_eq;
    logic          cmp_lt;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    max_val;
    logic [3:0]    min_val;
    logic [CW-1:0] n_rise;
    logic [CW-1:0] n_same;
    logic [CW-1:0] n_fall;
`ifdef CMP_ONEHOT_CHECK_EN
    logic          flag_err;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cur_mode;      // 0 normal, 1 gt&lt both high, 2 all flags low
    logic [3:0] m_prev;
    bit         m_err;

    always #5 clk = ~clk;

    // Stand-in for the external comparator, with fault injection.
    assign cmp_gt = (cur_mode == 1) ? 1'b1 : (cur_mode == 2) ? 1'b0 : (cmp_a > cmp_b);
    assign cmp_eq = (cur_mode != 0) ? 1'b0 : (cmp_a == cmp_b);
    assign cmp_lt = (cur_mode == 1) ? 1'b1 : (cur_mode == 2) ? 1'b0 : (cmp_a < cmp_b);

    cmp_frame_stats #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_gt    (cmp_gt),
        .cmp_eq    (cmp_eq),
        .cmp_lt    (cmp_lt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .max_val   (max_val),
        .min_val   (min_val),
        .n_rise    (n_rise),
        .n_same    (n_same),
`ifdef CMP_ONEHOT_CHECK_EN
        .n_fall    (n_fall),
        .flag_err  (flag_err)
`else
        .n_fall    (n_fall)
`endif
    );

    typedef struct {
        logic [15:0] smp;
        int          bidx;
        int          bmode;
        int          hold;
        int          mx, mn, r, s, f;
        bit          err;
    } vec_t;

    typedef struct {
        int mx, mn, r, s, f;
        bit err;
    } exp_t;

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [15:0] pk(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [3:0] smp_at(input logic [15:0] s, input int i);
        return s[4*i +: 4];
    endfunction

    // Frame-level reference: statistics straight from the sample list.
    function automatic exp_t model(input logic [15:0] s, input int bidx, input int bmode,
                                   input bit err_in);
        exp_t e;
        int   cur;
        int   prv;
        e.mx = smp_at(s, 0); e.mn = smp_at(s, 0);
        e.r = 0; e.s = 0; e.f = 0; e.err = err_in;
        for (int i = 1; i < FL; i++) begin
            cur = smp_at(s, i);
            prv = smp_at(s, i - 1);
            if (cur > e.mx) e.mx = cur;
            if (cur < e.mn) e.mn = cur;
            if (i == bidx && bmode != 0) begin
`ifdef CMP_ONEHOT_CHECK_EN
                e.err = 1'b1;
`else
                if (bmode == 1) e.r++; else e.f++;
`endif
            end else if (cur > prv) e.r++;
            else if (cur == prv)    e.s++;
            else                    e.f++;
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the sample is taken.
    task automatic send_sample(input logic [3:0] d, input int mode);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        cur_mode = mode;
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_wait", in_ready, 1);
        check("cmp_a", cmp_a, d);
        check("cmp_b", cmp_b, m_prev);
        @(negedge clk);
        m_prev   = d;
        cur_mode = 0;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] s, input int bidx, input int bmode, input bit gaps);
        for (int i = 0; i < FL; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            send_sample(smp_at(s, i), (i == bidx) ? bmode : 0);
        end
    endtask

    task automatic check_fields(input exp_t e);
        check("max_val", max_val, e.mx);
        check("min_val", min_val, e.mn);
        check("n_rise", n_rise, e.r);
        check("n_same", n_same, e.s);
        check("n_fall", n_fall, e.f);
    endtask

    // Entered at the negedge right after the last sample was accepted.
    task automatic check_record(input exp_t e, input int hold, input logic [3:0] nxt);
        check("out_valid_rise", out_valid, 1);
        check("in_ready_report", in_ready, 0);
        check_fields(e);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = nxt;
            @(negedge clk);
            check("out_valid_hold", out_valid, 1);
            check("in_ready_hold", in_ready, 0);
            check_fields(e);
        end
        out_ready = 1'b1;
        in_valid  = (hold > 0);
        in_data   = nxt;
        @(negedge clk);
        check("out_valid_drop", out_valid, 0);
        check("in_ready_after", in_ready, 1);
`ifdef CMP_ONEHOT_CHECK_EN
        check("flag_err", flag_err, e.err);
`endif
        out_ready = 1'b0;
    endtask

    vec_t        tbl[5];
    logic [15:0] rs[31];

    initial begin
        exp_t e;
        logic [3:0] v;

        tbl[0] = '{pk(3,7,7,2),    -1, 0, 0, 7, 2, 1, 1, 1, 1'b0};
        tbl[1] = '{pk(5,5,5,5),    -1, 0, 5, 5, 5, 0, 3, 0, 1'b0};
        tbl[2] = '{pk(15,0,15,0),  -1, 0, 0, 15, 0, 1, 0, 2, 1'b0};
`ifdef CMP_ONEHOT_CHECK_EN
        tbl[3] = '{pk(3,7,7,2),     2, 1, 0, 7, 2, 1, 0, 1, 1'b1};
        tbl[4] = '{pk(0,15,15,15),  1, 2, 0, 15, 0, 0, 2, 0, 1'b1};
`else
        tbl[3] = '{pk(3,7,7,2),     2, 1, 0, 7, 2, 2, 0, 1, 1'b0};
        tbl[4] = '{pk(0,15,15,15),  1, 2, 0, 15, 0, 0, 2, 1, 1'b0};
`endif

        rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
        cur_mode = 0; m_prev = 4'd0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_cmp_b", cmp_b, 0);
        check_fields('{0, 0, 0, 0, 0, 1'b0});
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
`ifdef CMP_ONEHOT_CHECK_EN
        check("rst_flag_err", flag_err, 0);
`endif

        // Vector table
        for (int k = 0; k < 5; k++) begin
            send_frame(tbl[k].smp, tbl[k].bidx, tbl[k].bmode, 1'b0);
            e = '{tbl[k].mx, tbl[k].mn, tbl[k].r, tbl[k].s, tbl[k].f, tbl[k].err};
            check_record(e, tbl[k].hold, (k < 4) ? smp_at(tbl[k+1].smp, 0) : 4'd0);
        end

        // Reset in the middle of a frame
        send_sample(4'd9, 0);
        send_sample(4'd6, 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_cmp_b", cmp_b, 0);
        check_fields('{0, 0, 0, 0, 0, 1'b0});
`ifdef CMP_ONEHOT_CHECK_EN
        check("midrst_flag_err", flag_err, 0);
`endif
        @(negedge clk);
        rst = 1'b0; m_prev = 4'd0; m_err = 1'b0;
        @(negedge clk);
        send_frame(pk(1,2,3,4), -1, 0, 1'b0);
        check_record('{4, 1, 3, 0, 0, 1'b0}, 0, 4'd0);

        // Random frames against the reference model
        for (int k = 0; k < 31; k++) begin
            rs[k] = 16'd0;
            for (int i = 0; i < FL; i++) begin
                if (i > 0 && $urandom_range(0, 2) == 0) v = rs[k][4*(i-1) +: 4];
                else v = 4'($urandom_range(0, 15));
                rs[k][4*i +: 4] = v;
            end
        end
        for (int k = 0; k < 30; k++) begin
            send_frame(rs[k], -1, 0, 1'b1);
            e = model(rs[k], -1, 0, m_err);
            check_record(e, $urandom_range(0, 3), smp_at(rs[k+1], 0));
            m_err = e.err;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
